// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// Define MDU_FAST_MULT_EN to compute mult/multu in one cycle; div/divu always iterate.
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t             state_q;
    logic [WIDTH:0]     acc_q;
    logic [WIDTH-1:0]   q_q;
    logic [WIDTH-1:0]   opb_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               is_div_q;
    logic               neg_q;
    logic               neg_rem_q;
    logic               div0_q;
    logic               busy_q;
    logic               done_q;

    logic               sign_a;
    logic               sign_b;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH+1:0]   div_diff;
    logic               div_ge;
    logic [WIDTH:0]     acc_d;
    logic [WIDTH-1:0]   q_d;

    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   hi_d;
    logic [WIDTH-1:0]   lo_d;

    always_comb begin
        sign_a = ~op[0] & A[WIDTH-1];
        sign_b = ~op[0] & B[WIDTH-1];
        mag_a  = sign_a ? -A : A;
        mag_b  = sign_b ? -B : B;
    end

    // One iteration: multiply shifts the {acc,q} pair right after a conditional add,
    // divide shifts it left and does a restoring subtract against the divisor.
    always_comb begin
        mul_sum   = acc_q + (q_q[0] ? {1'b0, opb_q} : '0);
        div_shift = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, opb_q};
        div_ge    = ~div_diff[WIDTH+1];
        if (is_div_q) begin
            acc_d = div_ge ? div_diff[WIDTH:0] : div_shift;
            q_d   = {q_q[WIDTH-2:0], div_ge};
        end else begin
            acc_d = {1'b0, mul_sum[WIDTH:1]};
            q_d   = {mul_sum[0], q_q[WIDTH-1:1]};
        end
    end

    always_comb begin
`ifdef MDU_FAST_MULT_EN
        prod = {{WIDTH{1'b0}}, opb_q} * {{WIDTH{1'b0}}, q_q};
`else
        prod = {acc_q[WIDTH-1:0], q_q};
`endif
        prod_fix = neg_q ? -prod : prod;
        rem      = acc_q[WIDTH-1:0];
        if (is_div_q) begin
            // Divide by zero leaves an all-ones quotient and |A| as remainder;
            // restoring the dividend sign on the remainder yields hi=A.
            lo_d = (neg_q && !div0_q) ? -q_q : q_q;
            hi_d = neg_rem_q ? -rem : rem;
        end else begin
            lo_d = prod_fix[WIDTH-1:0];
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            q_q       <= '0;
            opb_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        is_div_q  <= op[1];
                        neg_q     <= sign_a ^ sign_b;
                        neg_rem_q <= sign_a;
                        div0_q    <= op[1] & (B == '0);
                        acc_q     <= '0;
                        cnt_q     <= '0;
                        busy_q    <= 1'b1;
                        if (op[1]) begin
                            opb_q <= mag_b;
                            q_q   <= mag_a;
                        end else begin
                            opb_q <= mag_a;
                            q_q   <= mag_b;
                        end
`ifdef MDU_FAST_MULT_EN
                        state_q <= op[1] ? RUN : FIX;
`else
                        state_q <= RUN;
`endif
                    end else begin
                        if (mthi) hi_q <= wdata;
                        if (mtlo) lo_q <= wdata;
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    q_q   <= q_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH - 1)) state_q <= FIX;
                end
                FIX: begin
                    hi_q    <= hi_d;
                    lo_q    <= lo_d;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit (honours MDU_FAST_MULT_EN latency).
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .mthi  (mthi),
        .mtlo  (mtlo),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for done after acceptance; n counts edges since the accepting edge.
    task automatic wait_done(input string tag, input int n0, input int lat,
                             input logic [31:0] ehi, input logic [31:0] elo);
        int n;
        int bad;
        n   = n0;
        bad = 0;
        while (done !== 1'b1 && n < 200) begin
            if (busy !== 1'b1) bad++;
            tick();
            n++;
        end
        check({tag, " latency"}, 32'(n), 32'(lat));
        check({tag, " busy window"}, 32'(bad), 32'd0);
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " busy end"}, 32'(busy), 32'd0);
        check({tag, " hi"}, hi, ehi);
        check({tag, " lo"}, lo, elo);
        tick();
        check({tag, " done pulse"}, 32'(done), 32'd0);
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
        int lat;
        lat = 33;
`ifdef MDU_FAST_MULT_EN
        if (!o[1]) lat = 1;
`endif
        op    = o;
        A     = a;
        B     = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        mthi  = 1'b0;
        mtlo  = 1'b0;
        A     = 32'hDEAD_BEEF;
        B     = 32'h0000_0001;
        op    = 2'b11;
        wait_done(tag, 0, lat, ehi, elo);
    endtask

    initial begin
        int n;
        int dcount;
        reset = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        A     = '0;
        B     = '0;
        mthi  = 1'b0;
        mtlo  = 1'b0;
        wdata = '0;
        repeat (2) tick();
        reset = 1'b0;
        check("reset hi", hi, 32'h0);
        check("reset lo", lo, 32'h0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        tick();
        check("idle done", 32'(done), 32'd0);

        run_op("mult -3*5", 2'b00, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_op("multu max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("mult minneg", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0);
        run_op("div -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu 100/7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14);
        run_op("div min/-1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
        run_op("divu by0", 2'b11, 32'h0000_1234, 32'h0, 32'h0000_1234, 32'hFFFF_FFFF);
        run_op("div neg by0", 2'b10, 32'hFFFF_FFF9, 32'h0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);

        // start beats same-cycle mthi/mtlo
        mthi  = 1'b1;
        mtlo  = 1'b1;
        wdata = 32'h77;
        run_op("start+mt", 2'b01, 32'd2, 32'd3, 32'h0, 32'd6);

        // start and mthi during busy are ignored
        op    = 2'b11;
        A     = 32'd100;
        B     = 32'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        start = 1'b1;
        op    = 2'b00;
        A     = 32'd3;
        B     = 32'd3;
        mthi  = 1'b1;
        wdata = 32'hDEAD;
        tick();
        start = 1'b0;
        mthi  = 1'b0;
        wait_done("busy conflict", 6, 33, 32'd2, 32'd14);
        repeat (5) tick();
        check("no queued op busy", 32'(busy), 32'd0);
        check("no queued op hi", hi, 32'd2);

        mthi  = 1'b1;
        wdata = 32'hAA;
        tick();
        mthi  = 1'b0;
        mtlo  = 1'b1;
        wdata = 32'h55;
        tick();
        mtlo  = 1'b0;
        check("mthi hi", hi, 32'hAA);
        check("mtlo lo", lo, 32'h55);
        check("mt done", 32'(done), 32'd0);
        mthi  = 1'b1;
        mtlo  = 1'b1;
        wdata = 32'h3C;
        tick();
        mthi  = 1'b0;
        mtlo  = 1'b0;
        check("mt both hi", hi, 32'h3C);
        check("mt both lo", lo, 32'h3C);
        check("mt both done", 32'(done), 32'd0);

        // reset in the middle of a divide
        op    = 2'b10;
        A     = 32'hFFFF_FFF9;
        B     = 32'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        check("mid div busy", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort busy", 32'(busy), 32'd0);
        check("abort hi", hi, 32'h0);
        check("abort lo", lo, 32'h0);
        check("abort done", 32'(done), 32'd0);
        dcount = 0;
        for (n = 0; n < 40; n++) begin
            tick();
            if (done === 1'b1) dcount++;
        end
        check("abort no done", 32'(dcount), 32'd0);
        check("abort hi after", hi, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
